// File: rtl/pci_pkg.sv
// Shared PCI definitions used by the target, the initiator and the protocol checker:
// bus command encodings and the target state encoding.
package pci_pkg;

   typedef enum logic [3:0] {
      CMD_MEM_RD = 4'b0110,
      CMD_MEM_WR = 4'b0111
   } pci_cmd_e;

   typedef enum logic [2:0] {
      TGT_IDLE,
      TGT_CLAIM,
      TGT_WAIT,
      TGT_DATA,
      TGT_TURN
   } tgt_state_e;

endpackage

// File: rtl/pci_tgt_regfile.sv
// Word array behind the PCI target window: one byte-enable write port, one
// asynchronous read port, whole array cleared by the asynchronous reset.
module pci_tgt_regfile #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [3:0]           be,
   input  logic [31:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [31:0]          rdata
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [31:0] mem [DEPTH];

   // NOTE: the array sits in the reset branch on purpose: a reset must leave every
   // word reading zero, so this stays flops rather than an inferred RAM macro.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pci_target_mem.sv
// PCI memory target claiming a 2^ADDR_BITS-word window at BASE_ADDR, with linear
// bursts and initiator waits. Define PCI_TGT_PARITY_EN to add the PAR/PAR_OE outputs.
module pci_target_mem
   import pci_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          ADDR_BITS   = 4,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        FRAME_,
   input  logic        IRDY_,
   input  logic [3:0]  C_BE_,
   input  logic [31:0] AD_IN,
   output logic [31:0] AD_OUT,
   output logic        AD_OE,
   output logic        TRDY_,
   output logic        DEVSEL_,
   output logic        CTL_OE
`ifdef PCI_TGT_PARITY_EN
   ,
   output logic        PAR,
   output logic        PAR_OE
`endif
);

   // Cycles from the address edge to the first TRDY_; reads add the AD turnaround.
   localparam logic [2:0]           WR_DLY  = 3'(WAIT_STATES);
   localparam logic [2:0]           RD_DLY  = 3'(WAIT_STATES + 1);
   localparam logic [ADDR_BITS-1:0] IDX_ONE = 1;

   tgt_state_e           state, state_nxt;
   logic                 frame_q;
   logic                 is_rd, is_rd_nxt;
   logic [ADDR_BITS-1:0] idx, idx_nxt;
   logic [2:0]           cnt, cnt_nxt;
   logic                 we;
   logic [31:0]          rdata;
   logic                 hit, claim, abort;

   assign hit   = (AD_IN[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]) && (AD_IN[1:0] == 2'b00);
   assign claim = frame_q && !FRAME_ && hit && ((C_BE_ == CMD_MEM_RD) || (C_BE_ == CMD_MEM_WR));
   assign abort = FRAME_ && IRDY_;

   // NOTE: every variable gets a default at the top so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      is_rd_nxt = is_rd;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      we        = 1'b0;
      case (state)
         TGT_IDLE, TGT_TURN: begin
            state_nxt = TGT_IDLE;
            if (claim) begin
               is_rd_nxt = (C_BE_ == CMD_MEM_RD);
               idx_nxt   = AD_IN[ADDR_BITS+1:2];
               cnt_nxt   = is_rd_nxt ? RD_DLY : WR_DLY;
               state_nxt = (cnt_nxt == 3'd0) ? TGT_DATA : TGT_CLAIM;
            end
         end
         TGT_CLAIM, TGT_WAIT: begin
            if (abort)              state_nxt = TGT_TURN;
            else if (cnt == 3'd1)   state_nxt = TGT_DATA;
            else begin
               cnt_nxt   = cnt - 3'd1;
               state_nxt = TGT_WAIT;
            end
         end
         TGT_DATA: begin
            if (!IRDY_) begin
               we      = !is_rd;
               idx_nxt = idx + IDX_ONE;
               if (FRAME_) state_nxt = TGT_TURN;
            end else if (abort) begin
               state_nxt = TGT_TURN;
            end
         end
         default: state_nxt = TGT_IDLE;
      endcase
   end

   pci_tgt_regfile #(.ADDR_BITS(ADDR_BITS)) u_regfile (
      .clk   (clk),
      .reset_(reset_),
      .we    (we),
      .waddr (idx),
      .be    (~C_BE_),
      .wdata (AD_IN),
      .raddr (idx_nxt),
      .rdata (rdata)
   );

   // Outputs are registered from the next state, so the pins never see an input combinationally.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state   <= TGT_IDLE;
         frame_q <= 1'b1;
         is_rd   <= 1'b0;
         idx     <= '0;
         cnt     <= '0;
         TRDY_   <= 1'b1;
         DEVSEL_ <= 1'b1;
         CTL_OE  <= 1'b0;
         AD_OE   <= 1'b0;
         AD_OUT  <= '0;
      end else begin
         state   <= state_nxt;
         frame_q <= FRAME_;
         is_rd   <= is_rd_nxt;
         idx     <= idx_nxt;
         cnt     <= cnt_nxt;
         TRDY_   <= (state_nxt != TGT_DATA);
         DEVSEL_ <= !(state_nxt inside {TGT_CLAIM, TGT_WAIT, TGT_DATA});
         CTL_OE  <= (state_nxt != TGT_IDLE);
         AD_OE   <= (state_nxt == TGT_DATA) && is_rd_nxt;
         AD_OUT  <= ((state_nxt == TGT_DATA) && is_rd_nxt) ? rdata : 32'h0;
      end
   end

`ifdef PCI_TGT_PARITY_EN
   // Parity covers the read data and byte enables of the data cycle just completed.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         PAR    <= 1'b0;
         PAR_OE <= 1'b0;
      end else begin
         PAR_OE <= AD_OE;
         if (!TRDY_ && AD_OE) PAR <= ^{AD_OUT, C_BE_};
      end
   end
`else
   // Default build: no parity outputs and no parity logic.
`endif

endmodule

// File: tb/tb_pci_target_mem.sv
// Self-checking bench for pci_target_mem: a zero-wait target at 0x1000 driven by a
// vector table, plus a two-wait-state target at 0x3000 for latency and reset cases.
module tb_pci_target_mem;
   import pci_pkg::*;

   logic        clk = 1'b0;
   logic        reset_;
   logic        FRAME_, IRDY_;
   logic [3:0]  C_BE_;
   logic [31:0] AD_IN;

   logic [31:0] ad_out0, ad_out2;
   logic        ad_oe0, trdy0, devsel0, ctl_oe0;
   logic        ad_oe2, trdy2, devsel2, ctl_oe2;
`ifdef PCI_TGT_PARITY_EN
   logic        par0, par_oe0, par2, par_oe2;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pci_target_mem #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset_(reset_), .FRAME_(FRAME_), .IRDY_(IRDY_), .C_BE_(C_BE_), .AD_IN(AD_IN),
      .AD_OUT(ad_out0), .AD_OE(ad_oe0), .TRDY_(trdy0), .DEVSEL_(devsel0), .CTL_OE(ctl_oe0)
`ifdef PCI_TGT_PARITY_EN
      , .PAR(par0), .PAR_OE(par_oe0)
`endif
   );

   pci_target_mem #(.BASE_ADDR(32'h0000_3000), .ADDR_BITS(4), .WAIT_STATES(2)) u2 (
      .clk(clk), .reset_(reset_), .FRAME_(FRAME_), .IRDY_(IRDY_), .C_BE_(C_BE_), .AD_IN(AD_IN),
      .AD_OUT(ad_out2), .AD_OE(ad_oe2), .TRDY_(trdy2), .DEVSEL_(devsel2), .CTL_OE(ctl_oe2)
`ifdef PCI_TGT_PARITY_EN
      , .PAR(par2), .PAR_OE(par_oe2)
`endif
   );

   typedef enum {P_IDLE, P_CLAIM, P_WR, P_RD, P_TURN} phase_e;

   typedef struct {
      logic        frame;
      logic        irdy;
      logic [3:0]  cbe;
      logic [31:0] ad;
      phase_e      ph;
      logic [31:0] ad_exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected {TRDY_, DEVSEL_, CTL_OE, AD_OE} for each bus phase seen by the target.
   function automatic logic [3:0] ph_bits(input phase_e p);
      case (p)
         P_CLAIM: return 4'b1010;
         P_WR:    return 4'b0010;
         P_RD:    return 4'b0011;
         P_TURN:  return 4'b1110;
         default: return 4'b1100;
      endcase
   endfunction

   function automatic vec_t mk(input logic f, input logic i, input logic [3:0] c,
                               input logic [31:0] a, input phase_e p, input logic [31:0] d = 32'h0);
      vec_t v;
      v.frame = f; v.irdy = i; v.cbe = c; v.ad = a; v.ph = p; v.ad_exp = d;
      return v;
   endfunction

   task automatic drive(input logic f, input logic i, input logic [3:0] c, input logic [31:0] a);
      FRAME_ = f; IRDY_ = i; C_BE_ = c; AD_IN = a;
   endtask

   function automatic logic [3:0] ctl_of(input bit sel2);
      return sel2 ? {trdy2, devsel2, ctl_oe2, ad_oe2} : {trdy0, devsel0, ctl_oe0, ad_oe0};
   endfunction

   // Single-phase write; lat = cycles after the address edge until TRDY_ is seen low.
   task automatic do_write(input bit sel2, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] cbe, output int lat);
      bit seen = 0;
      lat = 0;
      @(negedge clk) drive(1'b0, 1'b1, CMD_MEM_WR, addr);
      @(negedge clk) drive(1'b1, 1'b0, cbe, data);
      for (int k = 1; k <= 10 && !seen; k++) begin
         if (k > 1) @(negedge clk);
         if (ctl_of(sel2)[3] == 1'b0) begin seen = 1; lat = k; end
      end
      if (!seen) begin failures++; $display("FAIL write_timeout: no TRDY_ for %h", addr); end
      @(negedge clk) drive(1'b1, 1'b1, 4'hF, 32'h0);
      @(negedge clk);
   endtask

   // Single-phase read; returns data, latency to first TRDY_ low, and parity seen afterwards.
   task automatic do_read(input bit sel2, input logic [31:0] addr, output logic [31:0] data,
                          output int lat, output logic [1:0] par_seen);
      bit seen = 0;
      lat = 0; data = 'x; par_seen = 2'b00;
      @(negedge clk) drive(1'b0, 1'b1, CMD_MEM_RD, addr);
      @(negedge clk) drive(1'b1, 1'b0, 4'h0, 32'h0);
      for (int k = 1; k <= 10 && !seen; k++) begin
         if (k > 1) @(negedge clk);
         if (ctl_of(sel2)[3] == 1'b0) begin
            seen = 1; lat = k;
            data = sel2 ? ad_out2 : ad_out0;
         end
      end
      if (!seen) begin failures++; $display("FAIL read_timeout: no TRDY_ for %h", addr); end
      @(negedge clk);
`ifdef PCI_TGT_PARITY_EN
      par_seen = sel2 ? {par_oe2, par2} : {par_oe0, par0};
`endif
      drive(1'b1, 1'b1, 4'hF, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  par;
      int          lat;

      reset_ = 1'b0;
      drive(1'b1, 1'b1, 4'hF, 32'h0);
      repeat (2) @(negedge clk);
      check("reset_ctl", {28'h0, ctl_of(0)}, 32'hC);
      check("reset_ad_out", ad_out0, 32'h0);
      reset_ = 1'b1;

      // single write 0x1004 and readback
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      vecs.push_back(mk(0, 1, 4'h7, 32'h0000_1004, P_IDLE));
      vecs.push_back(mk(1, 0, 4'h0, 32'hDEAD_BEEF, P_WR));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      vecs.push_back(mk(0, 1, 4'h6, 32'h0000_1004, P_IDLE));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,         P_CLAIM));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,         P_RD, 32'hDEAD_BEEF));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      // burst write 14,15,0,1 with an initiator wait on the third beat
      vecs.push_back(mk(0, 1, 4'h7, 32'h0000_1038, P_IDLE));
      vecs.push_back(mk(0, 0, 4'h0, 32'hB000_000E, P_WR));
      vecs.push_back(mk(0, 0, 4'h0, 32'hB000_000F, P_WR));
      vecs.push_back(mk(0, 1, 4'h0, 32'hFFFF_FFFF, P_WR));
      vecs.push_back(mk(0, 0, 4'h0, 32'hB000_0000, P_WR));
      vecs.push_back(mk(1, 0, 4'h0, 32'hB000_0001, P_WR));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      // full write then back-to-back byte-enable write to word 2
      vecs.push_back(mk(0, 1, 4'h7, 32'h0000_1008, P_IDLE));
      vecs.push_back(mk(1, 0, 4'h0, 32'hAAAA_AAAA, P_WR));
      vecs.push_back(mk(0, 1, 4'h7, 32'h0000_1008, P_TURN));
      vecs.push_back(mk(1, 0, 4'hA, 32'h1122_3344, P_WR));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      // burst read 14,15,0,1,2 with a wait on the second beat
      vecs.push_back(mk(0, 1, 4'h6, 32'h0000_1038, P_IDLE));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,         P_CLAIM));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,         P_RD, 32'hB000_000E));
      vecs.push_back(mk(0, 1, 4'h0, 32'h0,         P_RD, 32'hB000_000F));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,         P_RD, 32'hB000_000F));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,         P_RD, 32'hB000_0000));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,         P_RD, 32'hB000_0001));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,         P_RD, 32'hAA22_AA44));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      // address miss, then I/O read command inside the window
      vecs.push_back(mk(0, 1, 4'h7, 32'h0000_2000, P_IDLE));
      vecs.push_back(mk(1, 0, 4'h0, 32'h1234_5678, P_IDLE));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      vecs.push_back(mk(0, 1, 4'h2, 32'h0000_1000, P_IDLE));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,         P_IDLE));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));
      // master abort during the claim cycle
      vecs.push_back(mk(0, 1, 4'h6, 32'h0000_1000, P_IDLE));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_CLAIM));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_TURN));
      vecs.push_back(mk(1, 1, 4'hF, 32'h0,         P_IDLE));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         check($sformatf("vec%0d_ctl", i), {28'h0, ctl_of(0)}, {28'h0, ph_bits(vecs[i].ph)});
         if (vecs[i].ph == P_RD) check($sformatf("vec%0d_ad_out", i), ad_out0, vecs[i].ad_exp);
         check($sformatf("vec%0d_other_idle", i), {28'h0, ctl_of(1)}, 32'hC);
         drive(vecs[i].frame, vecs[i].irdy, vecs[i].cbe, vecs[i].ad);
      end

      // two-wait-state target: write lands at A+3, read data at A+4
      do_write(1, 32'h0000_3004, 32'hCAFE_F00D, 4'h0, lat);
      check("ws2_write_latency", lat, 3);
      do_read(1, 32'h0000_3004, rd, lat, par);
      check("ws2_read_latency", lat, 4);
      check("ws2_read_data", rd, 32'hCAFE_F00D);

`ifdef PCI_TGT_PARITY_EN
      do_write(0, 32'h0000_1000, 32'h0000_0001, 4'h0, lat);
      do_read(0, 32'h0000_1000, rd, lat, par);
      check("par_read_data", rd, 32'h1);
      check("par_after_xfer", {30'h0, par}, 32'h3);
`endif

      // reset in the middle of a read burst
      @(negedge clk) drive(1'b0, 1'b1, CMD_MEM_RD, 32'h0000_1038);
      @(negedge clk) drive(1'b0, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      check("burst_active_before_reset", {28'h0, ctl_of(0)}, 32'h3);
      #2 reset_ = 1'b0;
      #1;
      check("reset_mid_burst_ctl", {28'h0, ctl_of(0)}, 32'hC);
      check("reset_mid_burst_ad_out", ad_out0, 32'h0);
      drive(1'b1, 1'b1, 4'hF, 32'h0);
      @(negedge clk) reset_ = 1'b1;
      do_read(0, 32'h0000_1038, rd, lat, par);
      check("cleared_word14", rd, 32'h0);
      check("zero_ws_read_latency", lat, 2);
      do_read(0, 32'h0000_1008, rd, lat, par);
      check("cleared_word2", rd, 32'h0);
      do_read(1, 32'h0000_3004, rd, lat, par);
      check("cleared_ws2_word1", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
